// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver: hex decode, double-buffered frames, blank gap, leading-zero blanking.
// Ports: clk, reset, on, load, digit_data, dp_in, lz_sup, [blink_mask if SEG_SCAN_BLINK_EN] -> frame_done, segs.
module seg_scan_driver #(
  parameter int DIGITS = 4,
  parameter int DWELL  = 50000,
  parameter int BLANK  = 500
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  on,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   digit_data,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  lz_sup,
`ifdef SEG_SCAN_BLINK_EN
  input  logic [DIGITS-1:0]     blink_mask,
`endif
  output logic                  frame_done,
  output logic [8+DIGITS-1:0]   segs
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(DWELL + BLANK + 1);
  localparam logic [CW-1:0] DW_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] BL_LAST =
    CW'((BLANK > 0) ? BLANK - 1 : 0);
  localparam logic [IW-1:0] IX_LAST = IW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    GAP
  } state_t;

  state_t                state;
  logic [IW-1:0]         idx;
  logic [CW-1:0]         cnt;
  logic [4*DIGITS-1:0]   pend_d;
  logic [DIGITS-1:0]     pend_p;
  logic [4*DIGITS-1:0]   act_d;
  logic [DIGITS-1:0]     act_p;
`ifdef SEG_SCAN_BLINK_EN
  logic [5:0]            fcnt;
`endif

  logic                  last;
  logic                  show_end;
  logic                  gap_end;
  logic                  slot_end;
  logic                  boundary;
  logic [IW-1:0]         nxt_idx;
  logic [3:0]            nib;
  logic                  dpl;
  logic                  lzb;
  logic                  dark;
  logic [DIGITS-1:0]     en;
  logic [8+DIGITS-1:0]   show_segs;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    last     = (idx == IX_LAST);
    show_end = (state == SHOW) && (cnt == DW_LAST);
    gap_end  = (state == GAP) && (cnt == BL_LAST);
    slot_end = (BLANK == 0) ? show_end : gap_end;
    boundary = on && slot_end && last;
    nxt_idx  = last ? '0 : idx + 1'b1;
    nib      = act_d[{idx, 2'b00} +: 4];
    dpl      = act_p[idx];
    // Blank when this nibble and every higher one is zero.
    lzb      = lz_sup && (idx != '0) &&
               ((act_d >> {idx, 2'b00}) == '0);
    dark     = 1'b0;
`ifdef SEG_SCAN_BLINK_EN
    dark     = blink_mask[idx] && fcnt[5];
`endif
    for (int k = 0; k < DIGITS; k++) begin
      en[k] = (idx != IW'(k));
    end
    if (dark)
      show_segs = '1;
    else
      show_segs = {en, ~dpl,
                   lzb ? 7'h7F : hex7(nib)};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      pend_d     <= '0;
      pend_p     <= '0;
      act_d      <= '0;
      act_p      <= '0;
      frame_done <= 1'b0;
      segs       <= '1;
`ifdef SEG_SCAN_BLINK_EN
      fcnt       <= '0;
`endif
    end else begin
      frame_done <= boundary;
`ifdef SEG_SCAN_BLINK_EN
      if (boundary)
        fcnt <= fcnt + 1'b1;
`endif
      if (load) begin
        pend_d <= digit_data;
        pend_p <= dp_in;
      end
      // Idle or frame-boundary loads pass straight through.
      if (load && (state == IDLE || boundary)) begin
        act_d <= digit_data;
        act_p <= dp_in;
      end else if (boundary) begin
        act_d <= pend_d;
        act_p <= pend_p;
      end
      if (on && state == SHOW)
        segs <= show_segs;
      else
        segs <= '1;
      if (!on) begin
        state <= IDLE;
        idx   <= '0;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            state <= SHOW;
            idx   <= '0;
            cnt   <= '0;
          end
          SHOW: begin
            if (cnt == DW_LAST) begin
              cnt <= '0;
              if (BLANK == 0) begin
                idx <= nxt_idx;
              end else begin
                state <= GAP;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          GAP: begin
            if (cnt == BL_LAST) begin
              cnt   <= '0;
              idx   <= nxt_idx;
              state <= SHOW;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            idx   <= '0;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule
